compute_unit_sequencer: RTL and testbench
=========================================

# compute_unit_sequencer

Sequences one SIMD instruction through a single compute unit. It accepts an instruction descriptor over a valid/ready handshake and walks the element loop, issuing one buffer read per cycle. It drives opcode, fn, fixed-point format and accumulator-reset into the compute unit, and issues result writes aligned to the compute unit's output register. It sits between the SIMD instruction decoder and the compute unit plus its operand/result buffers.

## Interface
- ADDR_WIDTH, 32: buffer address width (base/stride width).
- COUNT_WIDTH, 16: element count and reduction length width.
- OPCODE_BITS, 4: opcode width.
- FUNCTION_BITS, 4: fn width.
- RD_LAT, 1: cycles from rd_en to operand data at compute unit inputs (≥1).
- CU_LAT, 1: compute unit input-to-data_out latency. Must be 1 when reduction is used.

- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset (asserted = 0).
- inst_valid / inst_ready  in/out  1  descriptor handshake; transfer when both are 1.
- inst_opcode  in  OPCODE_BITS, inst_fn  in  FUNCTION_BITS  operation.
- inst_src0_base, inst_src1_base, inst_dst_base  in  ADDR_WIDTH  start addresses.
- inst_src0_stride, inst_src1_stride, inst_dst_stride  in  ADDR_WIDTH  per-step increments.
- inst_count  in  COUNT_WIDTH  element count N.
- inst_red_len  in  COUNT_WIDTH  reduction group length L; 0 or 1 means elementwise.
- inst_dest_int, inst_src1_int, inst_src2_int  in  8  integer-bit formats.
- rd_en  out  1; rd_addr0, rd_addr1  out  ADDR_WIDTH  operand reads.
- cu_opcode  out  OPCODE_BITS, cu_fn  out  FUNCTION_BITS; cu_dest_int/cu_src1_int/cu_src2_int  out  8  compute unit configuration.
- cu_acc_reset  out  1; cu_reduction_flag  out  1.
- wr_en  out  1; wr_addr  out  ADDR_WIDTH  result write, same cycle data_out is valid.
- busy  out  1; done  out  1  one-cycle completion pulse.

## Operation
- FSM states: IDLE, ISSUE, DRAIN, DONE.
  - inst_ready = 1 only in IDLE.
  - On handshake, all descriptor fields are latched and the FSM moves to ISSUE. If N = 0 it moves directly to DONE, with no reads or writes.
- ISSUE: one rd_en per cycle for k = 0..N-1.
  - rd_addr0 = src0_base + k·src0_stride; rd_addr1 = src1_base + k·src1_stride.
  - Addresses are accumulated by adders and wrap modulo 2^ADDR_WIDTH.
  - After the element k = N-1, the FSM moves to DRAIN.
- DRAIN: no reads. The FSM waits until the pipeline valid shift register (depth RD_LAT+CU_LAT) is empty, then moves to DONE.
- DONE: done = 1 for one cycle, then IDLE.
- Elementwise mode (L ≤ 1): every element is written to wr_addr = dst_base + k·dst_stride. cu_reduction_flag = 0 and cu_acc_reset = 1 on every element.
- Reduction mode (L > 1): cu_reduction_flag = 1.
  - cu_acc_reset = 1 on the first element of each group, 0 otherwise.
  - wr_en is asserted only for the last element of a group, at dst_base + g·dst_stride, where g is the group index.
  - If N is not a multiple of L, the final partial group is closed and written at element N-1.
- cu_opcode, cu_fn and the format fields are held constant from the cycle after accept through DONE. They are 0 in IDLE.
- Per-element tags (valid, group-last, dst address) travel through the delay line.

## Timing
- Reset values: inst_ready, rd_en, wr_en, busy, done, cu_acc_reset and cu_reduction_flag are 0; all addresses, cu_opcode, cu_fn and the format fields are 0.
- After reset deasserts: inst_ready = 1 in the first cycle.
- Handshake at cycle 0:
  - busy = 1 from cycle 1 until the DONE cycle inclusive.
  - rd_en is asserted in cycles 1..N.
- cu_acc_reset for element k is asserted in cycle 1+k+RD_LAT, aligned with the operand data.
- wr_en for element k is asserted in cycle 1+k+RD_LAT+CU_LAT.
- done is asserted in the cycle after the last wr_en; inst_ready returns 1 the next cycle.
  - Example with RD_LAT = CU_LAT = 1: wr_en in cycles 3..N+2, done in cycle N+3, ready in cycle N+4.
- inst_valid while not in IDLE: held off, no effect.
- Reset asserted mid-instruction:
  - Immediate abort.
  - Pipeline tags are cleared, so no further wr_en.
  - The FSM returns to IDLE.
  - The descriptor is lost.

## Structure
- Shared package simd_pkg:
  - opcode constants ARITH = 4'b0000, CALC = 4'b0001, COMP = 4'b0010, CAST = 4'b0011;
  - FSM state encoding;
  - the descriptor field layout.
- One sub-module, seq_tag_pipe: a parameterized-depth shift register carrying {valid, acc_reset, last, dst_addr}, asynchronously cleared by reset.

## Test plan
- Elementwise add, N = 4, src0_base = 0x10, stride 1, dst_base = 0x40:
  - rd_en in cycles 1–4, addresses 0x10–0x13;
  - wr_en in cycles 3–6, addresses 0x40–0x43;
  - done in cycle 7.
- Reduction, N = 6, L = 3, dst_base = 0x80, dst_stride = 2:
  - cu_acc_reset at elements 0 and 3;
  - exactly 2 writes, to 0x80 and 0x82.
- N = 0: done in cycle 1 after accept; zero rd_en/wr_en; ready again in cycle 2.
- Address wrap: src0_base = 0xFFFFFFFE, stride 1, N = 3 → rd_addr0 = 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000.
- Reset pulled low at cycle 3 of an N = 8 instruction: all outputs 0 immediately, no later wr_en, inst_ready = 1 after release.
- Back-to-back descriptors:
  - inst_valid held high, second descriptor accepted exactly in the cycle after the first done;
  - inst_ready low throughout the first instruction.

Source files
------------

// File: rtl/simd_pkg.sv
// Shared SIMD sequencer definitions: opcode constants, FSM encoding and the
// fixed-width fixed-point format fields carried in every descriptor.
package simd_pkg;

  localparam logic [3:0] ARITH = 4'b0000;
  localparam logic [3:0] CALC  = 4'b0001;
  localparam logic [3:0] COMP  = 4'b0010;
  localparam logic [3:0] CAST  = 4'b0011;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } seq_state_t;

  // Integer-bit counts of the destination and both sources
  typedef struct packed {
    logic [7:0] dest_int;
    logic [7:0] src1_int;
    logic [7:0] src2_int;
  } fmt_t;

endpackage

// File: rtl/seq_tag_pipe.sv
// Per-element tag delay line from read issue to result write-back, so that
// acc-reset lines up with operand data and write-enable with data_out.
module seq_tag_pipe #(
  parameter int DEPTH      = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int ACC_TAP    = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic                  in_acc_reset,
  input  logic                  in_last,
  input  logic [ADDR_WIDTH-1:0] in_dst_addr,
  output logic                  pending,
  output logic                  acc_reset_tap,
  output logic                  last_tail,
  output logic [ADDR_WIDTH-1:0] dst_addr_tail
);

  typedef struct packed {
    logic                  valid;
    logic                  acc_reset;
    logic                  last;
    logic [ADDR_WIDTH-1:0] dst_addr;
  } tag_t;

  tag_t             stage_reg [DEPTH];
  logic [DEPTH-1:0] pending_vec;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) stage_reg[i] <= '0;
    end else begin
      stage_reg[0] <= {in_valid, in_acc_reset, in_last, in_dst_addr};
      for (int i = 1; i < DEPTH; i++) stage_reg[i] <= stage_reg[i-1];
    end
  end

  // Pending = an element has not yet reached the write-back stage
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_pend
      if (gi < DEPTH - 1) begin : g_mid
        assign pending_vec[gi] = stage_reg[gi].valid;
      end else begin : g_tail
        assign pending_vec[gi] = 1'b0;
      end
    end
  endgenerate

  assign pending       = |pending_vec;
  assign acc_reset_tap = stage_reg[ACC_TAP].valid && stage_reg[ACC_TAP].acc_reset;
  assign last_tail     = stage_reg[DEPTH-1].valid && stage_reg[DEPTH-1].last;
  assign dst_addr_tail = stage_reg[DEPTH-1].dst_addr;

endmodule

// File: rtl/compute_unit_sequencer.sv
// Walks the element loop of one SIMD instruction: strided operand reads,
// compute-unit configuration, and reduction-aware result writes.
module compute_unit_sequencer
  import simd_pkg::*;
#(
  parameter int ADDR_WIDTH    = 32,
  parameter int COUNT_WIDTH   = 16,
  parameter int OPCODE_BITS   = 4,
  parameter int FUNCTION_BITS = 4,
  parameter int RD_LAT        = 1,
  parameter int CU_LAT        = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     inst_valid,
  output logic                     inst_ready,
  input  logic [OPCODE_BITS-1:0]   inst_opcode,
  input  logic [FUNCTION_BITS-1:0] inst_fn,
  input  logic [ADDR_WIDTH-1:0]    inst_src0_base,
  input  logic [ADDR_WIDTH-1:0]    inst_src1_base,
  input  logic [ADDR_WIDTH-1:0]    inst_dst_base,
  input  logic [ADDR_WIDTH-1:0]    inst_src0_stride,
  input  logic [ADDR_WIDTH-1:0]    inst_src1_stride,
  input  logic [ADDR_WIDTH-1:0]    inst_dst_stride,
  input  logic [COUNT_WIDTH-1:0]   inst_count,
  input  logic [COUNT_WIDTH-1:0]   inst_red_len,
  input  logic [7:0]               inst_dest_int,
  input  logic [7:0]               inst_src1_int,
  input  logic [7:0]               inst_src2_int,
  output logic                     rd_en,
  output logic [ADDR_WIDTH-1:0]    rd_addr0,
  output logic [ADDR_WIDTH-1:0]    rd_addr1,
  output logic [OPCODE_BITS-1:0]   cu_opcode,
  output logic [FUNCTION_BITS-1:0] cu_fn,
  output logic [7:0]               cu_dest_int,
  output logic [7:0]               cu_src1_int,
  output logic [7:0]               cu_src2_int,
  output logic                     cu_acc_reset,
  output logic                     cu_reduction_flag,
  output logic                     wr_en,
  output logic [ADDR_WIDTH-1:0]    wr_addr,
  output logic                     busy,
  output logic                     done
);

  localparam int PIPE_DEPTH = RD_LAT + CU_LAT;

  typedef struct packed {
    logic [OPCODE_BITS-1:0]   opcode;
    logic [FUNCTION_BITS-1:0] fn;
    fmt_t                     fmt;
    logic [COUNT_WIDTH-1:0]   count;
    logic [COUNT_WIDTH-1:0]   red_len;
    logic [ADDR_WIDTH-1:0]    src0_stride;
    logic [ADDR_WIDTH-1:0]    src1_stride;
    logic [ADDR_WIDTH-1:0]    dst_stride;
  } desc_t;

  seq_state_t             state_reg, state_next;
  desc_t                  desc_reg;
  logic [ADDR_WIDTH-1:0]  src0_addr_reg, src1_addr_reg, dst_addr_reg;
  logic [COUNT_WIDTH-1:0] elem_reg, grp_pos_reg;
  logic                   red_mode_reg;

  logic                   accept, issue, last_elem, group_last, elem_acc_reset;
  logic                   pipe_pending, pipe_acc_reset, pipe_last;
  logic [ADDR_WIDTH-1:0]  pipe_dst_addr;

  assign accept    = inst_valid && inst_ready;
  assign issue     = (state_reg == ISSUE);
  assign last_elem = (elem_reg == desc_reg.count - COUNT_WIDTH'(1));

  // A group closes at its L-th element or at the final element, whichever is first
  assign group_last     = red_mode_reg ?
                          ((grp_pos_reg == desc_reg.red_len - COUNT_WIDTH'(1)) || last_elem) : 1'b1;
  assign elem_acc_reset = red_mode_reg ? (grp_pos_reg == '0) : 1'b1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = (inst_count == '0) ? DONE : ISSUE;
      ISSUE:   if (last_elem) state_next = DRAIN;
      DRAIN:   if (!pipe_pending) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // inst_ready is also masked by reset so it reads 0 while reset is held
  always_comb begin
    inst_ready        = (state_reg == IDLE) && reset;
    busy              = (state_reg != IDLE);
    done              = (state_reg == DONE);
    rd_en             = issue;
    rd_addr0          = issue ? src0_addr_reg : '0;
    rd_addr1          = issue ? src1_addr_reg : '0;
    cu_opcode         = busy ? desc_reg.opcode : '0;
    cu_fn             = busy ? desc_reg.fn : '0;
    cu_dest_int       = busy ? desc_reg.fmt.dest_int : '0;
    cu_src1_int       = busy ? desc_reg.fmt.src1_int : '0;
    cu_src2_int       = busy ? desc_reg.fmt.src2_int : '0;
    cu_reduction_flag = busy && red_mode_reg;
    cu_acc_reset      = pipe_acc_reset;
    wr_en             = pipe_last;
    wr_addr           = pipe_last ? pipe_dst_addr : '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      desc_reg      <= '0;
      src0_addr_reg <= '0;
      src1_addr_reg <= '0;
      dst_addr_reg  <= '0;
      elem_reg      <= '0;
      grp_pos_reg   <= '0;
      red_mode_reg  <= 1'b0;
    end else if (accept) begin
      desc_reg.opcode       <= inst_opcode;
      desc_reg.fn           <= inst_fn;
      desc_reg.fmt.dest_int <= inst_dest_int;
      desc_reg.fmt.src1_int <= inst_src1_int;
      desc_reg.fmt.src2_int <= inst_src2_int;
      desc_reg.count        <= inst_count;
      desc_reg.red_len      <= inst_red_len;
      desc_reg.src0_stride  <= inst_src0_stride;
      desc_reg.src1_stride  <= inst_src1_stride;
      desc_reg.dst_stride   <= inst_dst_stride;
      src0_addr_reg         <= inst_src0_base;
      src1_addr_reg         <= inst_src1_base;
      dst_addr_reg          <= inst_dst_base;
      elem_reg              <= '0;
      grp_pos_reg           <= '0;
      red_mode_reg          <= (inst_red_len > COUNT_WIDTH'(1));
    end else if (issue) begin
      src0_addr_reg <= src0_addr_reg + desc_reg.src0_stride;
      src1_addr_reg <= src1_addr_reg + desc_reg.src1_stride;
      elem_reg      <= elem_reg + COUNT_WIDTH'(1);
      if (group_last) begin
        grp_pos_reg  <= '0;
        dst_addr_reg <= dst_addr_reg + desc_reg.dst_stride;
      end else begin
        grp_pos_reg  <= grp_pos_reg + COUNT_WIDTH'(1);
      end
    end
  end

  seq_tag_pipe #(
    .DEPTH      (PIPE_DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .ACC_TAP    (RD_LAT - 1)
  ) u_tag_pipe (
    .clk           (clk),
    .reset         (reset),
    .in_valid      (issue),
    .in_acc_reset  (elem_acc_reset),
    .in_last       (group_last),
    .in_dst_addr   (dst_addr_reg),
    .pending       (pipe_pending),
    .acc_reset_tap (pipe_acc_reset),
    .last_tail     (pipe_last),
    .dst_addr_tail (pipe_dst_addr)
  );

endmodule

// File: tb/tb_compute_unit_sequencer.sv
// Directed bench for compute_unit_sequencer with RD_LAT = CU_LAT = 1;
// cycle 0 is the handshake cycle of each instruction.
module tb_compute_unit_sequencer;
  import simd_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        inst_valid = 1'b0;
  logic        inst_ready;
  logic [3:0]  inst_opcode = '0, inst_fn = '0;
  logic [31:0] inst_src0_base = '0, inst_src1_base = '0, inst_dst_base = '0;
  logic [31:0] inst_src0_stride = '0, inst_src1_stride = '0, inst_dst_stride = '0;
  logic [15:0] inst_count = '0, inst_red_len = '0;
  logic [7:0]  inst_dest_int = 8'h08, inst_src1_int = 8'h04, inst_src2_int = 8'h02;
  logic        rd_en, wr_en, busy, done, cu_acc_reset, cu_reduction_flag;
  logic [31:0] rd_addr0, rd_addr1, wr_addr;
  logic [3:0]  cu_opcode, cu_fn;
  logic [7:0]  cu_dest_int, cu_src1_int, cu_src2_int;

  compute_unit_sequencer dut (
    .clk(clk), .reset(reset),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst_opcode(inst_opcode), .inst_fn(inst_fn),
    .inst_src0_base(inst_src0_base), .inst_src1_base(inst_src1_base), .inst_dst_base(inst_dst_base),
    .inst_src0_stride(inst_src0_stride), .inst_src1_stride(inst_src1_stride),
    .inst_dst_stride(inst_dst_stride),
    .inst_count(inst_count), .inst_red_len(inst_red_len),
    .inst_dest_int(inst_dest_int), .inst_src1_int(inst_src1_int), .inst_src2_int(inst_src2_int),
    .rd_en(rd_en), .rd_addr0(rd_addr0), .rd_addr1(rd_addr1),
    .cu_opcode(cu_opcode), .cu_fn(cu_fn),
    .cu_dest_int(cu_dest_int), .cu_src1_int(cu_src1_int), .cu_src2_int(cu_src2_int),
    .cu_acc_reset(cu_acc_reset), .cu_reduction_flag(cu_reduction_flag),
    .wr_en(wr_en), .wr_addr(wr_addr), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  int          rd_n, wr_n, acc_n, done_cyc;
  int          rd_c [16], wr_c [16], acc_c [16];
  logic [31:0] rd_a0 [16], rd_a1 [16], wr_a [16];
  logic [3:0]  snap_opcode, snap_fn;
  logic [23:0] snap_fmt;
  logic        snap_red, snap_busy1, snap_busy_done, snap_ready_after, snap_cfg_idle;

  task automatic set_fields(input logic [3:0] op, input logic [3:0] fn,
                            input logic [31:0] s0b, input logic [31:0] s0s,
                            input logic [31:0] s1b, input logic [31:0] s1s,
                            input logic [31:0] db, input logic [31:0] ds,
                            input logic [15:0] n, input logic [15:0] l);
    inst_opcode = op; inst_fn = fn;
    inst_src0_base = s0b; inst_src0_stride = s0s;
    inst_src1_base = s1b; inst_src1_stride = s1s;
    inst_dst_base = db;   inst_dst_stride = ds;
    inst_count = n;       inst_red_len = l;
  endtask

  // Presents a descriptor at cycle 0, returns 1 ns into cycle 1
  task automatic start_inst(input string tag, input logic [3:0] op, input logic [3:0] fn,
                            input logic [31:0] s0b, input logic [31:0] s0s,
                            input logic [31:0] s1b, input logic [31:0] s1s,
                            input logic [31:0] db, input logic [31:0] ds,
                            input logic [15:0] n, input logic [15:0] l);
    @(negedge clk);
    set_fields(op, fn, s0b, s0s, s1b, s1s, db, ds, n, l);
    inst_valid = 1'b1;
    check_val({tag, "_ready_at_accept"}, inst_ready, 1'b1);
    @(posedge clk);
    #1 inst_valid = 1'b0;
  endtask

  task automatic collect(input string tag, input int max_cyc);
    rd_n = 0; wr_n = 0; acc_n = 0; done_cyc = -1;
    for (int c = 1; c <= max_cyc; c++) begin
      @(negedge clk);
      if (rd_en && rd_n < 16) begin
        rd_c[rd_n] = c; rd_a0[rd_n] = rd_addr0; rd_a1[rd_n] = rd_addr1; rd_n++;
      end
      if (wr_en && wr_n < 16) begin
        wr_c[wr_n] = c; wr_a[wr_n] = wr_addr; wr_n++;
      end
      if (cu_acc_reset && acc_n < 16) begin
        acc_c[acc_n] = c; acc_n++;
      end
      if (c == 1) begin
        snap_opcode = cu_opcode; snap_fn = cu_fn;
        snap_fmt = {cu_dest_int, cu_src1_int, cu_src2_int};
        snap_red = cu_reduction_flag; snap_busy1 = busy;
      end
      if (done_cyc >= 0) begin
        snap_ready_after = inst_ready;
        snap_cfg_idle = (cu_opcode == 4'h0) && (cu_fn == 4'h0) && !busy && !cu_reduction_flag;
        break;
      end
      if (done) begin
        done_cyc = c; snap_busy_done = busy;
      end
    end
    if (done_cyc < 0) check_val({tag, "_done_timeout"}, 1'b0, 1'b1);
  endtask

  int ready_high, dcyc, rd_hits, wr_hits;

  initial begin
    // Reset state
    @(negedge clk);
    check_val("rst_ctrl", {inst_ready, rd_en, wr_en, busy, done, cu_acc_reset, cu_reduction_flag}, 7'h0);
    check_val("rst_addr", {rd_addr0, rd_addr1, wr_addr}, 96'h0);
    check_val("rst_cfg", {cu_opcode, cu_fn, cu_dest_int, cu_src1_int, cu_src2_int}, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    #1 check_val("rst_release_ready", inst_ready, 1'b1);
    $display("txn reset: checks=%0d failures=%0d", checks, failures);

    // Elementwise, N=4
    start_inst("ew", CALC, 4'h3, 32'h10, 32'h1, 32'h20, 32'h1, 32'h40, 32'h1, 16'd4, 16'd0);
    collect("ew", 30);
    check_val("ew_rd_n", rd_n, 4);
    check_val("ew_wr_n", wr_n, 4);
    check_val("ew_acc_n", acc_n, 4);
    for (int k = 0; k < 4; k++) begin
      check_val($sformatf("ew_rd_cyc%0d", k), rd_c[k], 1 + k);
      check_val($sformatf("ew_rd_a0_%0d", k), rd_a0[k], 32'h10 + k);
      check_val($sformatf("ew_rd_a1_%0d", k), rd_a1[k], 32'h20 + k);
      check_val($sformatf("ew_wr_cyc%0d", k), wr_c[k], 3 + k);
      check_val($sformatf("ew_wr_addr%0d", k), wr_a[k], 32'h40 + k);
      check_val($sformatf("ew_acc_cyc%0d", k), acc_c[k], 2 + k);
    end
    check_val("ew_done_cyc", done_cyc, 7);
    check_val("ew_cfg", {snap_opcode, snap_fn, snap_fmt}, {CALC, 4'h3, 24'h080402});
    check_val("ew_red_flag", snap_red, 1'b0);
    check_val("ew_busy", {snap_busy1, snap_busy_done}, 2'b11);
    check_val("ew_ready_after", snap_ready_after, 1'b1);
    check_val("ew_cfg_idle", snap_cfg_idle, 1'b1);
    $display("txn elementwise N=4: done_cyc=%0d writes=%0d failures=%0d", done_cyc, wr_n, failures);

    // Reduction, N=6, L=3
    start_inst("red", ARITH, 4'h1, 32'h0, 32'h1, 32'h100, 32'h1, 32'h80, 32'h2, 16'd6, 16'd3);
    collect("red", 30);
    check_val("red_rd_n", rd_n, 6);
    check_val("red_acc_n", acc_n, 2);
    check_val("red_acc_cyc0", acc_c[0], 2);
    check_val("red_acc_cyc1", acc_c[1], 5);
    check_val("red_wr_n", wr_n, 2);
    check_val("red_wr_cyc0", wr_c[0], 5);
    check_val("red_wr_addr0", wr_a[0], 32'h80);
    check_val("red_wr_cyc1", wr_c[1], 8);
    check_val("red_wr_addr1", wr_a[1], 32'h82);
    check_val("red_flag", snap_red, 1'b1);
    check_val("red_done_cyc", done_cyc, 9);
    $display("txn reduction N=6 L=3: writes=%0d failures=%0d", wr_n, failures);

    // Partial final group, N=5, L=2
    start_inst("part", COMP, 4'h0, 32'h0, 32'h1, 32'h0, 32'h1, 32'h100, 32'h4, 16'd5, 16'd2);
    collect("part", 30);
    check_val("part_wr_n", wr_n, 3);
    for (int g = 0; g < 3; g++) begin
      check_val($sformatf("part_wr_cyc%0d", g), wr_c[g], (g == 2) ? 7 : 4 + 2 * g);
      check_val($sformatf("part_wr_addr%0d", g), wr_a[g], 32'h100 + 4 * g);
      check_val($sformatf("part_acc_cyc%0d", g), acc_c[g], 2 + 2 * g);
    end
    check_val("part_acc_n", acc_n, 3);
    check_val("part_done_cyc", done_cyc, 8);
    $display("txn partial N=5 L=2: writes=%0d failures=%0d", wr_n, failures);

    // N=0
    start_inst("zero", CAST, 4'h2, 32'h10, 32'h1, 32'h20, 32'h1, 32'h40, 32'h1, 16'd0, 16'd0);
    collect("zero", 10);
    check_val("zero_done_cyc", done_cyc, 1);
    check_val("zero_rd_wr", {rd_n[7:0], wr_n[7:0]}, 16'h0);
    check_val("zero_ready_cyc2", snap_ready_after, 1'b1);
    $display("txn zero-count: done_cyc=%0d failures=%0d", done_cyc, failures);

    // Address wrap, src1 walks downward with stride -1
    start_inst("wrap", ARITH, 4'h0, 32'hFFFF_FFFE, 32'h1, 32'h5, 32'hFFFF_FFFF, 32'h0, 32'h1, 16'd3, 16'd1);
    collect("wrap", 20);
    check_val("wrap_rd_n", rd_n, 3);
    check_val("wrap_a0_0", rd_a0[0], 32'hFFFF_FFFE);
    check_val("wrap_a0_1", rd_a0[1], 32'hFFFF_FFFF);
    check_val("wrap_a0_2", rd_a0[2], 32'h0000_0000);
    check_val("wrap_a1_2", rd_a1[2], 32'h3);
    check_val("wrap_done_cyc", done_cyc, 6);
    $display("txn address wrap: last_a0=0x%0h failures=%0d", rd_a0[2], failures);

    // Reset in the middle of an N=8 instruction
    start_inst("mid", CALC, 4'h5, 32'h10, 32'h1, 32'h20, 32'h1, 32'h40, 32'h1, 16'd8, 16'd0);
    @(negedge clk); @(negedge clk); @(negedge clk);
    check_val("mid_wr_before_reset", wr_en, 1'b1);
    reset = 1'b0;
    #1;
    check_val("mid_ctrl_cleared", {inst_ready, rd_en, wr_en, busy, done, cu_acc_reset, cu_reduction_flag}, 7'h0);
    check_val("mid_out_cleared", {rd_addr0, wr_addr, cu_opcode, cu_fn, cu_dest_int}, 80'h0);
    @(negedge clk); @(negedge clk);
    reset = 1'b1;
    #1 check_val("mid_ready_release", inst_ready, 1'b1);
    rd_hits = 0; wr_hits = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (rd_en) rd_hits++;
      if (wr_en) wr_hits++;
    end
    check_val("mid_no_late_rd_wr", {rd_hits[7:0], wr_hits[7:0]}, 16'h0);
    check_val("mid_idle_ready", inst_ready, 1'b1);
    $display("txn mid-reset: late_wr=%0d failures=%0d", wr_hits, failures);

    // Back-to-back: valid held high, fields switch to the second descriptor
    start_inst("b2b", ARITH, 4'h0, 32'h200, 32'h1, 32'h0, 32'h1, 32'h300, 32'h1, 16'd2, 16'd0);
    inst_valid = 1'b1;
    set_fields(CALC, 4'h1, 32'h500, 32'h1, 32'h0, 32'h1, 32'h600, 32'h1, 16'd1, 16'd0);
    ready_high = 0; dcyc = -1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (c == 2) check_val("b2b_first_rd_a0_1", rd_addr0, 32'h201);
      if (dcyc >= 0) begin
        check_val("b2b_ready_after_done", inst_ready, 1'b1);
        break;
      end
      if (inst_ready) ready_high++;
      if (done) dcyc = c;
    end
    check_val("b2b_first_done_cyc", dcyc, 5);
    check_val("b2b_ready_low", ready_high, 0);
    @(posedge clk);
    #1 inst_valid = 1'b0;
    collect("b2b2", 20);
    check_val("b2b2_rd_n", rd_n, 1);
    check_val("b2b2_rd_a0", rd_a0[0], 32'h500);
    check_val("b2b2_wr", {wr_n[7:0], wr_c[0][7:0], wr_a[0]}, {8'd1, 8'd3, 32'h600});
    check_val("b2b2_done_cyc", done_cyc, 4);
    check_val("b2b2_opcode", snap_opcode, CALC);
    $display("txn back-to-back: first_done=%0d second_done=%0d failures=%0d", dcyc, done_cyc, failures);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
